gmux_sel_ctrl: RTL and testbench
================================

GMUX_SEL_CTRL -- requirements
Module: gmux_sel_ctrl

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 4: quiesce cycles with GATE_EN low before IS0 changes; legal range 1..255.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 8: cycles after the IS0 change before GATE_EN reasserts; legal range 1..255.
REQ-003 SHALL have port CLK, input, 1, the single clock; free-running system clock, never the muxed clock.
REQ-004 SHALL have port RST_N, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port REQ, input, 1, single-cycle switch request.
REQ-006 SHALL have port REQ_SEL, input, 1, target source: 0 = IP, 1 = IC; sampled with REQ.
REQ-007 SHALL have port IS0, output, 1, registered select driven to the GMUX_IP select pin.
REQ-008 SHALL have port GATE_EN, output, 1, downstream clock-enable, low while a switch is in progress.
REQ-009 SHALL have port BUSY, output, 1, high while a switch is in progress.
REQ-010 SHALL have port ACK, output, 1, one-cycle completion pulse.

Function
REQ-011 SHALL implement FSM states IDLE, DRAIN, SWITCH, SETTLE, DONE, plus an 8-bit down-counter.
REQ-012 SHALL accept REQ only in IDLE or DONE; REQ in DRAIN/SWITCH/SETTLE SHALL be ignored, with no queueing and no ACK.
REQ-013 Accepted REQ at cycle t with REQ_SEL != IS0: IDLE->DRAIN; BUSY=1 and GATE_EN=0 from t+1.
REQ-014 DRAIN SHALL last exactly HOLD_CYCLES cycles (t+1..t+HOLD_CYCLES), then one SWITCH cycle.
REQ-015 IS0 SHALL take REQ_SEL at t+HOLD_CYCLES+2 and SHALL change only on that edge.
REQ-016 SETTLE SHALL last SETTLE_CYCLES cycles; GATE_EN SHALL stay low through t+HOLD_CYCLES+SETTLE_CYCLES+1.
REQ-017 DONE at t+HOLD_CYCLES+SETTLE_CYCLES+2: ACK=1 for one cycle, GATE_EN=1, BUSY=0; next cycle IDLE.
REQ-018 Accepted REQ with REQ_SEL == IS0: ACK at t+1 for one cycle; BUSY, GATE_EN and IS0 unchanged.
REQ-019 REQ accepted during DONE SHALL start a new sequence with t equal to the DONE cycle.
REQ-020 GATE_EN and IS0 SHALL never change in the same cycle.
REQ-021 The counter SHALL be loaded on state entry and SHALL never wrap; a parameter value of 1 SHALL give exactly one cycle.

Reset
REQ-022 RST_N low SHALL asynchronously force IDLE, IS0=0, GATE_EN=1, BUSY=0, ACK=0 and counter=0.
REQ-023 Reset asserted mid-sequence SHALL abort it with no ACK; IS0 SHALL return to 0.
REQ-024 Leaving reset SHALL be synchronous to CLK; the first REQ SHALL be accepted in the first cycle after RST_N rises.

Configuration
REQ-025 Macro GMUX_SEL_CTRL_LOCK_EN defined SHALL add input LOCK (1 bit) and output NACK (1 bit).
REQ-026 With the macro defined, REQ accepted while LOCK=1 SHALL cause no state change and SHALL pulse NACK at t+1 instead of ACK.
REQ-027 With the macro defined, LOCK SHALL have no effect on a sequence already in progress.
REQ-028 Without the macro, LOCK and NACK SHALL be absent and behaviour SHALL be as REQ-011..REQ-021.

Verification
REQ-029 Defaults, IS0=0, REQ=1 with REQ_SEL=1 at cycle 10 -> GATE_EN low at cycles 11..23, IS0=1 at cycle 16, ACK at cycle 24, BUSY low at cycle 24.
REQ-030 IS0=1, REQ=1 with REQ_SEL=1 at cycle 5 -> ACK at cycle 6; GATE_EN stays 1; BUSY stays 0.
REQ-031 REQ at cycle 10, second REQ with REQ_SEL=0 at cycle 15 -> ignored, single ACK at cycle 24, IS0 stays 1.
REQ-032 RST_N low at cycle 18 during SETTLE -> IS0=0, GATE_EN=1 immediately; no ACK ever observed.
REQ-033 HOLD_CYCLES=1 and SETTLE_CYCLES=1, REQ at cycle 0 -> GATE_EN low at cycles 1..3, IS0 changes at cycle 3, ACK at cycle 4.
REQ-034 GMUX_SEL_CTRL_LOCK_EN defined, LOCK=1, REQ at cycle 3 -> NACK at cycle 4, no ACK, IS0 and GATE_EN unchanged.

Source files
------------

// File: rtl/gmux_sel_ctrl.sv
// Glitch-free clock-mux select sequencer: gates the downstream clock, flips IS0, waits, then re-enables.
// Optional macro GMUX_SEL_CTRL_LOCK_EN adds a LOCK input that refuses requests with a NACK pulse.
module gmux_sel_ctrl #(
  parameter int HOLD_CYCLES   = 4,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic REQ,
  input  logic REQ_SEL,
`ifdef GMUX_SEL_CTRL_LOCK_EN
  input  logic LOCK,
  output logic NACK,
`endif
  output logic IS0,
  output logic GATE_EN,
  output logic BUSY,
  output logic ACK
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRAIN  = 3'd1,
    SWITCH = 3'd2,
    SETTLE = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t     state_reg, state_next;
  logic [7:0] cnt_reg, cnt_next;
  logic       is0_reg, is0_next;
  logic       sel_reg, sel_next;
  logic       locked;
  logic       req_window;

  assign req_window = (state_reg == IDLE) || (state_reg == DONE);

`ifdef GMUX_SEL_CTRL_LOCK_EN
  logic nack_reg;

  assign locked = LOCK;
  assign NACK   = nack_reg;

  // A refused request only produces the NACK pulse; the FSM path ignores it.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) nack_reg <= 1'b0;
    else        nack_reg <= req_window && REQ && LOCK;
  end
`else
  assign locked = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg <= IDLE;
      cnt_reg   <= 8'd0;
      is0_reg   <= 1'b0;
      sel_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      is0_reg   <= is0_next;
      sel_reg   <= sel_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    is0_next   = is0_reg;
    sel_next   = sel_reg;
    case (state_reg)
      IDLE, DONE: begin
        state_next = IDLE;
        cnt_next   = 8'd0;
        if (REQ && !locked) begin
          if (REQ_SEL != is0_reg) begin
            state_next = DRAIN;
            cnt_next   = 8'(HOLD_CYCLES);
            sel_next   = REQ_SEL;
          end else begin
            // Already on the requested source: acknowledge without gating.
            state_next = DONE;
          end
        end
      end
      DRAIN: begin
        if (cnt_reg <= 8'd1) begin
          state_next = SWITCH;
          cnt_next   = 8'd0;
        end else begin
          cnt_next = cnt_reg - 8'd1;
        end
      end
      SWITCH: begin
        is0_next   = sel_reg;
        state_next = SETTLE;
        cnt_next   = 8'(SETTLE_CYCLES);
      end
      SETTLE: begin
        if (cnt_reg <= 8'd1) begin
          state_next = DONE;
          cnt_next   = 8'd0;
        end else begin
          cnt_next = cnt_reg - 8'd1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 8'd0;
      end
    endcase
  end

  assign IS0     = is0_reg;
  assign BUSY    = (state_reg == DRAIN) || (state_reg == SWITCH) || (state_reg == SETTLE);
  assign GATE_EN = !BUSY;
  assign ACK     = (state_reg == DONE);

endmodule

// File: tb/tb_gmux_sel_ctrl.sv
// Directed bench for gmux_sel_ctrl: default-parameter instance plus a HOLD=1/SETTLE=1 instance.
// Define GMUX_SEL_CTRL_LOCK_EN to also exercise LOCK/NACK.
module tb_gmux_sel_ctrl;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic req = 1'b0, req_sel = 1'b0;
  logic is0, gate_en, busy, ack;
  logic req_f = 1'b0, req_sel_f = 1'b0;
  logic is0_f, gate_en_f, busy_f, ack_f;
`ifdef GMUX_SEL_CTRL_LOCK_EN
  logic lock = 1'b0;
  logic lock_f = 1'b0;
  logic nack, nack_f;
`endif

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  gmux_sel_ctrl u_dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .REQ     (req),
    .REQ_SEL (req_sel),
`ifdef GMUX_SEL_CTRL_LOCK_EN
    .LOCK    (lock),
    .NACK    (nack),
`endif
    .IS0     (is0),
    .GATE_EN (gate_en),
    .BUSY    (busy),
    .ACK     (ack)
  );

  gmux_sel_ctrl #(.HOLD_CYCLES(1), .SETTLE_CYCLES(1)) u_dut_fast (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .REQ     (req_f),
    .REQ_SEL (req_sel_f),
`ifdef GMUX_SEL_CTRL_LOCK_EN
    .LOCK    (lock_f),
    .NACK    (nack_f),
`endif
    .IS0     (is0_f),
    .GATE_EN (gate_en_f),
    .BUSY    (busy_f),
    .ACK     (ack_f)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0b expected=%0b", tag, cyc, obs, exp_v);
    end
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_is0", is0, 1'b0);
    chk("rst_gate", gate_en, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ack", ack, 1'b0);
    RST_N = 1'b1;
    cyc = 0;

    // Full switch at 10, ignored request at 15, back-to-back request in DONE at 24
    while (cyc < 10) tick();
    for (int i = 0; i < 30; i++) begin
      req = 1'b0;
      if (cyc == 10) begin req = 1'b1; req_sel = 1'b1; end
      if (cyc == 15) begin req = 1'b1; req_sel = 1'b0; end
      if (cyc == 24) begin req = 1'b1; req_sel = 1'b0; end
      tick();
      req = 1'b0;
      chk("a_gate", gate_en, !((cyc >= 11 && cyc <= 23) || (cyc >= 25 && cyc <= 37)));
      chk("a_busy", busy, (cyc >= 11 && cyc <= 23) || (cyc >= 25 && cyc <= 37));
      chk("a_is0", is0, (cyc >= 16 && cyc < 30));
      chk("a_ack", ack, (cyc == 24 || cyc == 38));
      $display("step A cycle=%0d is0=%0b gate=%0b busy=%0b ack=%0b", cyc, is0, gate_en, busy, ack);
    end

    // Request for the source already selected: immediate ACK, no gating
    for (int i = 0; i < 4; i++) begin
      req = (cyc == 41);
      req_sel = 1'b0;
      tick();
      req = 1'b0;
      chk("b_ack", ack, (cyc == 42));
      chk("b_gate", gate_en, 1'b1);
      chk("b_busy", busy, 1'b0);
      chk("b_is0", is0, 1'b0);
      $display("step B cycle=%0d is0=%0b gate=%0b busy=%0b ack=%0b", cyc, is0, gate_en, busy, ack);
    end

    // Fast instance takes a request right after reset; default instance is reset mid-SETTLE
    RST_N = 1'b0;
    tick(); tick();
    RST_N = 1'b1;
    cyc = 0;
    req_f = 1'b1;
    req_sel_f = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (cyc == 10) begin req = 1'b1; req_sel = 1'b1; end
      tick();
      req = 1'b0;
      req_f = 1'b0;
      if (cyc <= 6) begin
        chk("f_gate", gate_en_f, !(cyc >= 1 && cyc <= 3));
        chk("f_busy", busy_f, (cyc >= 1 && cyc <= 3));
        chk("f_is0", is0_f, (cyc >= 3));
        chk("f_ack", ack_f, (cyc == 4));
      end
      if (cyc == 18) begin
        chk("d_pre_is0", is0, 1'b1);
        chk("d_pre_gate", gate_en, 1'b0);
        RST_N = 1'b0;
        #1;
        chk("d_rst_is0", is0, 1'b0);
        chk("d_rst_gate", gate_en, 1'b1);
        chk("d_rst_busy", busy, 1'b0);
      end
      if (cyc == 20) RST_N = 1'b1;
      chk("d_ack", ack, 1'b0);
      $display("step D cycle=%0d is0=%0b gate=%0b ack=%0b fast_is0=%0b fast_gate=%0b fast_ack=%0b",
               cyc, is0, gate_en, ack, is0_f, gate_en_f, ack_f);
    end

`ifdef GMUX_SEL_CTRL_LOCK_EN
    // Locked request: NACK instead of ACK, nothing else moves
    cyc = 0;
    lock = 1'b1;
    for (int i = 0; i < 6; i++) begin
      req = (cyc == 3);
      req_sel = 1'b1;
      tick();
      req = 1'b0;
      chk("l_nack", nack, (cyc == 4));
      chk("l_ack", ack, 1'b0);
      chk("l_is0", is0, 1'b0);
      chk("l_gate", gate_en, 1'b1);
      $display("step L cycle=%0d nack=%0b ack=%0b is0=%0b gate=%0b", cyc, nack, ack, is0, gate_en);
    end
    lock = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
